// File: rtl/ar_br_cr_host_sequencer_if.sv
// Signal bundle between the host sequencer, its operand/result clients and the AR/BR/CR engine.
// The sequencer takes the slave view; the driving environment takes the master view.
interface ar_br_cr_host_sequencer_if;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_ar;
  logic [15:0] op_br;
  logic        start;
  logic [15:0] ar_data;
  logic [15:0] br_data;
  logic        busy;
  logic [15:0] cr_data;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [1:0]  res_tag;
  logic [15:0] jobs_done;
  logic        err;

  modport slave (
    input  op_valid, op_ar, op_br, busy, cr_data, res_ready,
    output op_ready, start, ar_data, br_data, res_valid, res_data, res_tag, jobs_done, err
  );

  modport master (
    output op_valid, op_ar, op_br, busy, cr_data, res_ready,
    input  op_ready, start, ar_data, br_data, res_valid, res_data, res_tag, jobs_done, err
  );
endinterface

// File: rtl/ar_br_cr_host_sequencer.sv
// Host-side initiator: queues AR/BR operand pairs, issues them to the engine one at a time,
// and holds each CR result (tagged with the AR sign class) until the consumer takes it.
module ar_br_cr_host_sequencer #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset_b,
  ar_br_cr_host_sequencer_if.slave    bus
);
  // state     | meaning
  // IDLE      | waiting for a queued job and a free result register
  // ISSUE     | start pulse to the engine, operands presented
  // WAIT_BUSY | waiting for the engine to raise busy (with timeout)
  // WAIT_DONE | waiting for busy to fall, then capture CR
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  function automatic logic [1:0] ar_class(input logic [15:0] a);
    if (a == 16'h0000) return 2'b00;
    else if (!a[15])   return 2'b01;
    else               return 2'b10;
  endfunction

  state_e        state_q, state_d;
  logic [15:0]   fifo_ar_q [DEPTH];
  logic [15:0]   fifo_br_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   ar_q, ar_d, br_q, br_d;
  logic [1:0]    tag_q, tag_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          res_valid_q, res_valid_d;
  logic [15:0]   res_data_q, res_data_d;
  logic [1:0]    res_tag_q, res_tag_d;
  logic [15:0]   jobs_done_q, jobs_done_d;
  logic          err_q, err_d;
  logic          full, push, pop, capture;

  assign full = (count_q == CW'(DEPTH));
  assign push = bus.op_valid && !full;

  always_comb begin
    state_d     = state_q;
    ar_d        = ar_q;
    br_d        = br_q;
    tag_d       = tag_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    pop         = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && (!res_valid_q || bus.res_ready)) begin
          pop     = 1'b1;
          ar_d    = fifo_ar_q[rd_ptr_q];
          br_d    = fifo_br_q[rd_ptr_q];
          tag_d   = ar_class(fifo_ar_q[rd_ptr_q]);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = TW'(BUSY_TIMEOUT - 1);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == '0) begin
          // Engine never answered: drop the job, keep running.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.busy) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    jobs_done_d = jobs_done_q;
    // A fresh capture takes priority over a same-cycle consume.
    if (capture) begin
      res_valid_d = 1'b1;
      res_data_d  = bus.cr_data;
      res_tag_d   = tag_q;
      jobs_done_d = jobs_done_q + 16'd1;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ar_q[wr_ptr_q] <= bus.op_ar;
      fifo_br_q[wr_ptr_q] <= bus.op_br;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ar_q        <= '0;
      br_q        <= '0;
      tag_q       <= '0;
      tmo_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      jobs_done_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ar_q        <= ar_d;
      br_q        <= br_d;
      tag_q       <= tag_d;
      tmo_q       <= tmo_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      jobs_done_q <= jobs_done_d;
      err_q       <= err_d;
    end
  end

  assign bus.op_ready  = !full;
  assign bus.start     = (state_q == ISSUE);
  assign bus.ar_data   = ar_q;
  assign bus.br_data   = br_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.jobs_done = jobs_done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ar_br_cr_host_sequencer.sv
// Directed bench for the AR/BR/CR host sequencer with a behavioural engine responder.
module tb_ar_br_cr_host_sequencer;
  logic clk = 1'b0;
  logic reset_b = 1'b0;
  int   vec = 0;
  int   miss = 0;

  int   eng_lat = 1;
  bit   eng_hang = 1'b0;
  int   eng_cnt;
  int   cyc = 0;
  int   start_cnt = 0;
  int   last_start_cyc = 0;
  int   prev_start_cyc = 0;

  ar_br_cr_host_sequencer_if bus();

  ar_br_cr_host_sequencer #(.DEPTH(4), .BUSY_TIMEOUT(15)) dut (
    .clk    (clk),
    .reset_b(reset_b),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] eng_fn(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h0000) return 16'h0000;
    else if (!a[15])   return b << 1;
    else               return {a[15], a[15:1]};
  endfunction

  // Engine responder: busy for eng_lat cycles after seeing start, unless hung.
  always @(posedge clk) begin
    if (!reset_b) begin
      bus.busy    <= 1'b0;
      bus.cr_data <= 16'h0000;
      eng_cnt     <= 0;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) bus.busy <= 1'b0;
    end else if (bus.start && !eng_hang) begin
      bus.busy    <= 1'b1;
      bus.cr_data <= eng_fn(bus.ar_data, bus.br_data);
      eng_cnt     <= eng_lat;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.start) begin
      start_cnt      <= start_cnt + 1;
      prev_start_cyc <= last_start_cyc;
      last_start_cyc <= cyc;
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    bus.op_valid = 1'b1;
    bus.op_ar    = a;
    bus.op_br    = b;
    while (!bus.op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    if (n >= 100) begin
      vec++; miss++;
      $display("FAIL push_timeout: op_ready stayed %b, required 1", bus.op_ready);
    end
  endtask

  task automatic wait_result(input logic [15:0] exp_d, input logic [1:0] exp_t, input string nm);
    int n = 0;
    @(negedge clk);
    while (!bus.res_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    vec++;
    if (bus.res_valid !== 1'b1) begin
      miss++;
      $display("FAIL %s_valid: res_valid=%b, required 1", nm, bus.res_valid);
    end
    vec++;
    if (bus.res_data !== exp_d) begin
      miss++;
      $display("FAIL %s_data: res_data=%h, required %h", nm, bus.res_data, exp_d);
    end
    vec++;
    if (bus.res_tag !== exp_t) begin
      miss++;
      $display("FAIL %s_tag: res_tag=%b, required %b", nm, bus.res_tag, exp_t);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    @(negedge clk);
    while (!bus.start && n < 60) begin
      @(negedge clk);
      n++;
    end
    vec++;
    if (bus.start !== 1'b1) begin
      miss++;
      $display("FAIL %s_start: start=%b, required 1", nm, bus.start);
    end
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    vec++; if (bus.op_ready !== 1'b1)    begin miss++; $display("FAIL rst_op_ready: %b, required 1", bus.op_ready); end
    vec++; if (bus.start !== 1'b0)       begin miss++; $display("FAIL rst_start: %b, required 0", bus.start); end
    vec++; if (bus.ar_data !== 16'h0)    begin miss++; $display("FAIL rst_ar_data: %h, required 0000", bus.ar_data); end
    vec++; if (bus.res_valid !== 1'b0)   begin miss++; $display("FAIL rst_res_valid: %b, required 0", bus.res_valid); end
    vec++; if (bus.jobs_done !== 16'h0)  begin miss++; $display("FAIL rst_jobs_done: %h, required 0000", bus.jobs_done); end
    vec++; if (bus.err !== 1'b0)         begin miss++; $display("FAIL rst_err: %b, required 0", bus.err); end
  endtask

  task automatic test_basic();
    push(16'h0005, 16'h0003);
    wait_start("basic");
    vec++; if (bus.ar_data !== 16'h0005) begin miss++; $display("FAIL basic_ar_data: %h, required 0005", bus.ar_data); end
    vec++; if (bus.br_data !== 16'h0003) begin miss++; $display("FAIL basic_br_data: %h, required 0003", bus.br_data); end
    @(negedge clk);
    vec++; if (bus.start !== 1'b0)       begin miss++; $display("FAIL basic_start_width: start=%b, required 0", bus.start); end
    wait_result(16'h0006, 2'b01, "basic");
    vec++; if (bus.jobs_done !== 16'd1)  begin miss++; $display("FAIL basic_jobs: %0d, required 1", bus.jobs_done); end
  endtask

  task automatic test_classes();
    push(16'hFFFC, 16'h1234);
    wait_result(16'hFFFE, 2'b10, "neg");
    push(16'h0000, 16'h7FFF);
    wait_result(16'h0000, 2'b00, "zero");
    vec++; if (bus.jobs_done !== 16'd3)  begin miss++; $display("FAIL classes_jobs: %0d, required 3", bus.jobs_done); end
  endtask

  task automatic test_fill();
    int snap;
    snap = start_cnt;
    bus.res_ready = 1'b0;
    push(16'h0001, 16'h0010);
    push(16'h8000, 16'h0000);
    push(16'h0000, 16'h0005);
    push(16'h7FFF, 16'h4000);
    push(16'hFFFF, 16'h0000);
    @(negedge clk);
    vec++; if (bus.op_ready !== 1'b0)    begin miss++; $display("FAIL fill_op_ready: %b, required 0", bus.op_ready); end
    repeat (15) @(negedge clk);
    vec++; if (start_cnt - snap !== 1)   begin miss++; $display("FAIL fill_starts: %0d, required 1", start_cnt - snap); end
    vec++; if (bus.jobs_done !== 16'd4)  begin miss++; $display("FAIL fill_jobs: %0d, required 4", bus.jobs_done); end
    wait_result(16'h0020, 2'b01, "fill0");
    wait_result(16'hC000, 2'b10, "fill1");
    wait_result(16'h0000, 2'b00, "fill2");
    wait_result(16'h8000, 2'b01, "fill3");
    wait_result(16'hFFFF, 2'b10, "fill4");
    vec++; if (bus.jobs_done !== 16'd8)  begin miss++; $display("FAIL fill_jobs_end: %0d, required 8", bus.jobs_done); end
  endtask

  task automatic test_back_to_back();
    int snap;
    snap = start_cnt;
    bus.res_ready = 1'b1;
    push(16'h0002, 16'h0001);
    push(16'h0003, 16'h0002);
    repeat (14) @(negedge clk);
    bus.res_ready = 1'b0;
    vec++; if (start_cnt - snap !== 2)   begin miss++; $display("FAIL b2b_starts: %0d, required 2", start_cnt - snap); end
    vec++; if (last_start_cyc - prev_start_cyc !== 4) begin miss++; $display("FAIL b2b_spacing: %0d, required 4", last_start_cyc - prev_start_cyc); end
    vec++; if (bus.jobs_done !== 16'd10) begin miss++; $display("FAIL b2b_jobs: %0d, required 10", bus.jobs_done); end
    vec++; if (bus.res_valid !== 1'b0)   begin miss++; $display("FAIL b2b_drained: res_valid=%b, required 0", bus.res_valid); end
  endtask

  task automatic test_timeout();
    eng_hang = 1'b1;
    push(16'h0002, 16'h0001);
    wait_start("tmo");
    repeat (15) @(posedge clk);
    @(negedge clk);
    vec++; if (bus.err !== 1'b0)         begin miss++; $display("FAIL tmo_early: err=%b, required 0", bus.err); end
    @(posedge clk);
    @(negedge clk);
    vec++; if (bus.err !== 1'b1)         begin miss++; $display("FAIL tmo_err: err=%b, required 1", bus.err); end
    vec++; if (bus.res_valid !== 1'b0)   begin miss++; $display("FAIL tmo_res_valid: %b, required 0", bus.res_valid); end
    vec++; if (bus.jobs_done !== 16'd10) begin miss++; $display("FAIL tmo_jobs: %0d, required 10", bus.jobs_done); end
    eng_hang = 1'b0;
    push(16'h0003, 16'h0004);
    wait_result(16'h0008, 2'b01, "tmo_next");
    vec++; if (bus.err !== 1'b1)         begin miss++; $display("FAIL tmo_sticky: err=%b, required 1", bus.err); end
    vec++; if (bus.jobs_done !== 16'd11) begin miss++; $display("FAIL tmo_next_jobs: %0d, required 11", bus.jobs_done); end
  endtask

  task automatic test_reset_mid();
    int snap;
    eng_lat = 6;
    push(16'h0001, 16'h0001);
    push(16'h0002, 16'h0002);
    push(16'h0003, 16'h0003);
    @(negedge clk);
    @(negedge clk);
    vec++; if (bus.busy !== 1'b1)        begin miss++; $display("FAIL mid_busy: busy=%b, required 1", bus.busy); end
    reset_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vec++; if (bus.start !== 1'b0)       begin miss++; $display("FAIL mid_start: %b, required 0", bus.start); end
    vec++; if (bus.res_valid !== 1'b0)   begin miss++; $display("FAIL mid_res_valid: %b, required 0", bus.res_valid); end
    vec++; if (bus.op_ready !== 1'b1)    begin miss++; $display("FAIL mid_op_ready: %b, required 1", bus.op_ready); end
    vec++; if (bus.jobs_done !== 16'd0)  begin miss++; $display("FAIL mid_jobs: %0d, required 0", bus.jobs_done); end
    vec++; if (bus.err !== 1'b0)         begin miss++; $display("FAIL mid_err: %b, required 0", bus.err); end
    reset_b = 1'b1;
    eng_lat = 1;
    snap = start_cnt;
    repeat (20) @(negedge clk);
    vec++; if (start_cnt !== snap)       begin miss++; $display("FAIL mid_no_start: %0d starts, required 0", start_cnt - snap); end
    push(16'h0004, 16'h0002);
    wait_result(16'h0004, 2'b01, "mid_after");
    vec++; if (bus.jobs_done !== 16'd1)  begin miss++; $display("FAIL mid_after_jobs: %0d, required 1", bus.jobs_done); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.jobs_done_q = 16'hFFFF;
    @(negedge clk);
    release dut.jobs_done_q;
    push(16'h0001, 16'h0001);
    wait_result(16'h0002, 2'b01, "wrap");
    vec++; if (bus.jobs_done !== 16'h0000) begin miss++; $display("FAIL wrap_jobs: %h, required 0000", bus.jobs_done); end
  endtask

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_ar     = 16'h0;
    bus.op_br     = 16'h0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_classes();
    test_fill();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
